// File: rtl/bridge_pkg.sv
// Shared types and constants for the dev_bridge CPU-to-peripheral bridge.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0]  REG_IRQ_MASK = 4'h0;
    localparam logic [3:0]  REG_IRQ_PEND = 4'h4;
    localparam logic [31:0] RD_ERR_VAL   = 32'h0;

endpackage

// File: rtl/bridge_irq_ctrl.sv
// Interrupt edge detect, IRQ_MASK / IRQ_PEND registers and the registered int_req.
module bridge_irq_ctrl #(
    parameter int N_DEV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_DEV-1:0] dev_irq,
    input  logic             mask_we,
    input  logic             pend_clr,
    input  logic [N_DEV-1:0] wdata,
    output logic [N_DEV-1:0] irq_mask,
    output logic [N_DEV-1:0] irq_pend,
    output logic             int_req
);

    logic [N_DEV-1:0] prev;
    logic [N_DEV-1:0] rise;
    logic [N_DEV-1:0] clr;

    assign rise = dev_irq & ~prev;
    assign clr  = pend_clr ? wdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev     <= '0;
            irq_mask <= '0;
            irq_pend <= '0;
            int_req  <= 1'b0;
        end else begin
            prev <= dev_irq;
            if (mask_we) begin
                irq_mask <= wdata;
            end
            // Clear is applied before the OR so a new edge wins over a same-cycle clear.
            irq_pend <= (irq_pend & ~clr) | rise;
            int_req  <= |(irq_pend & irq_mask);
        end
    end

endmodule

// File: rtl/dev_bridge.sv
// CPU-to-peripheral bridge: N decoded device windows, req/ready handshake, IRQ registers.
// Optional access timeout is built only when BRIDGE_TIMEOUT_EN is defined.
module dev_bridge
    import bridge_pkg::*;
#(
    parameter int          N_DEV       = 2,
    parameter logic [31:0] DEV_BASE    = 32'h0000_7F00,
    parameter int          SPAN_W      = 4,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pr_req,
    input  logic                  pr_we,
    input  logic [31:0]           pr_addr,
    input  logic [31:0]           pr_wd,
    output logic [31:0]           pr_rd,
    output logic                  pr_ready,
    output logic                  pr_err,
    output logic [N_DEV-1:0]      dev_sel,
    output logic                  dev_we,
    output logic [SPAN_W-1:0]     dev_addr,
    output logic [31:0]           dev_wd,
    input  logic [32*N_DEV-1:0]   dev_rd,
    input  logic [N_DEV-1:0]      dev_ack,
    input  logic [N_DEV-1:0]      dev_irq,
    output logic                  int_req
);

    state_t state, state_nxt;

    logic [31:0]      rel, idx, off;
    logic             in_range, is_dev, is_int, hit_mask, hit_pend;
    logic [N_DEV-1:0] sel_dec;
    logic             sel_ack, timed_out, accept;
    logic [31:0]      sel_rd;
    logic [N_DEV-1:0] irq_mask, irq_pend;

    assign rel      = pr_addr - DEV_BASE;
    assign in_range = pr_addr >= DEV_BASE;
    assign idx      = rel >> SPAN_W;
    assign off      = rel & ((32'd1 << SPAN_W) - 32'd1);
    assign is_dev   = in_range && (idx < 32'(N_DEV));
    assign is_int   = in_range && (idx == 32'(N_DEV));
    assign hit_mask = is_int && (off == 32'(REG_IRQ_MASK));
    assign hit_pend = is_int && (off == 32'(REG_IRQ_PEND));
    assign accept   = (state == IDLE) && pr_req;

    // Only the selected device's ack and read data are visible.
    always_comb begin
        sel_rd  = '0;
        sel_dec = '0;
        for (int i = 0; i < N_DEV; i++) begin
            sel_dec[i] = (idx == 32'(i));
            if (dev_sel[i]) begin
                sel_rd = sel_rd | dev_rd[32*i +: 32];
            end
        end
        sel_ack = |(dev_ack & dev_sel);
    end

`ifdef BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;

    assign timed_out = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == ACCESS && !sel_ack) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt is defaulted first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pr_req) state_nxt = is_dev ? ACCESS : DONE;
            ACCESS:  if (sel_ack || timed_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign pr_ready = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pr_rd    <= '0;
            pr_err   <= 1'b0;
            dev_sel  <= '0;
            dev_we   <= 1'b0;
            dev_addr <= '0;
            dev_wd   <= '0;
        end else begin
            case (state)
                IDLE: if (pr_req) begin
                    pr_err <= !is_dev && !is_int;
                    pr_rd  <= RD_ERR_VAL;
                    if (is_dev) begin
                        dev_sel  <= sel_dec;
                        dev_we   <= pr_we;
                        dev_addr <= rel[SPAN_W-1:0];
                        dev_wd   <= pr_wd;
                    end else if (is_int && !pr_we) begin
                        pr_rd <= hit_mask ? 32'(irq_mask) : hit_pend ? 32'(irq_pend) : '0;
                    end
                end
                ACCESS: if (sel_ack) begin
                    pr_rd   <= dev_we ? '0 : sel_rd;
                    pr_err  <= 1'b0;
                    dev_sel <= '0;
                    dev_we  <= 1'b0;
                end else if (timed_out) begin
                    pr_rd   <= RD_ERR_VAL;
                    pr_err  <= 1'b1;
                    dev_sel <= '0;
                    dev_we  <= 1'b0;
                end
                DONE:    pr_err <= 1'b0;
                default: ;
            endcase
        end
    end

    bridge_irq_ctrl #(.N_DEV(N_DEV)) u_irq (
        .clk      (clk),
        .reset    (reset),
        .dev_irq  (dev_irq),
        .mask_we  (accept && pr_we && hit_mask),
        .pend_clr (accept && pr_we && hit_pend),
        .wdata    (pr_wd[N_DEV-1:0]),
        .irq_mask (irq_mask),
        .irq_pend (irq_pend),
        .int_req  (int_req)
    );

endmodule

// File: tb/tb_dev_bridge.sv
// Scoreboard bench for dev_bridge: directed cases plus randomized accesses against a decode/IRQ model.
module tb_dev_bridge;

    localparam int          N_DEV  = 2;
    localparam logic [31:0] BASE   = 32'h0000_7F00;
    localparam int          WIN    = 16;
    localparam int          TO_CYC = 16;
`ifdef BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                pr_req, pr_we;
    logic [31:0]         pr_addr, pr_wd, pr_rd;
    logic                pr_ready, pr_err;
    logic [N_DEV-1:0]    dev_sel;
    logic                dev_we;
    logic [3:0]          dev_addr;
    logic [31:0]         dev_wd;
    logic [32*N_DEV-1:0] dev_rd;
    logic [N_DEV-1:0]    dev_ack, dev_irq;
    logic                int_req;

    dev_bridge dut (
        .clk(clk), .reset(reset), .pr_req(pr_req), .pr_we(pr_we), .pr_addr(pr_addr),
        .pr_wd(pr_wd), .pr_rd(pr_rd), .pr_ready(pr_ready), .pr_err(pr_err),
        .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wd(dev_wd),
        .dev_rd(dev_rd), .dev_ack(dev_ack), .dev_irq(dev_irq), .int_req(int_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          issue;
    } exp_t;

    exp_t             sb[$];
    int               n_vec = 0;
    int               n_bad = 0;
    int               cyc = 0;
    int               n_ready = 0;
    bit               got_ready;
    logic [N_DEV-1:0] m_mask = '0, m_pend = '0, m_irq = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every completion pulse is matched against the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        if (pr_ready === 1'b1) begin
            got_ready = 1'b1;
            n_ready++;
            if (sb.size() == 0) begin
                check("spurious_ready", 32'(pr_ready), 32'd0);
            end else begin
                e = sb.pop_front();
                check("pr_rd", pr_rd, e.rd);
                check("pr_err", 32'(pr_err), 32'(e.err));
                check("latency", 32'(cyc - e.issue + 1), 32'(e.lat));
            end
        end
    end

    // Reference decode: 0 = device, 1 = internal registers, 2 = unmapped.
    function automatic int classify(input logic [31:0] a, output int idx, output int off);
        idx = 0;
        off = 0;
        if (a < BASE) return 2;
        idx = int'((a - BASE) / WIN);
        off = int'((a - BASE) % WIN);
        if (idx < N_DEV) return 0;
        if (idx == N_DEV) return 1;
        return 2;
    endfunction

    // Called just after a rising edge. d = ACCESS cycle on which ack is given (0 = never).
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input int d, input logic [N_DEV-1:0] irq_new);
        int          kind, idx, off, cnt;
        exp_t        e;
        logic [N_DEV-1:0] exp_sel;
        kind = classify(addr, idx, off);
        for (int i = 0; i < N_DEV; i++) dev_rd[32*i +: 32] = $urandom();
        e.rd = '0;
        e.err = 1'b0;
        e.lat = 2;
        e.issue = cyc;
        if (kind == 0) begin
            e.rd  = we ? 32'h0 : dev_rd[32*idx +: 32];
            e.err = (d == 0);
            e.lat = (d == 0) ? 2 + TO_CYC : 2 + d;
            if (d == 0) e.rd = '0;
        end else if (kind == 1) begin
            if (!we) e.rd = (off == 0) ? 32'(m_mask) : (off == 4) ? 32'(m_pend) : 32'h0;
            else if (off == 0) m_mask = wd[N_DEV-1:0];
            else if (off == 4) m_pend = m_pend & ~wd[N_DEV-1:0];
        end else begin
            e.err = 1'b1;
        end
        m_pend  = m_pend | (irq_new & ~m_irq);
        m_irq   = irq_new;
        dev_irq = irq_new;
        sb.push_back(e);
        got_ready = 1'b0;
        pr_req = 1'b1; pr_we = we; pr_addr = addr; pr_wd = wd;
        exp_sel = N_DEV'(1) << idx;
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (got_ready) break;
            if (dev_sel != '0) begin
                cnt++;
                if (cnt == 1) begin
                    check("dev_sel", 32'(dev_sel), 32'(exp_sel));
                    check("dev_addr", 32'(dev_addr), 32'(off));
                    check("dev_we", 32'(dev_we), 32'(we));
                    if (we) check("dev_wd", dev_wd, wd);
                end
            end
            dev_ack = (d != 0 && cnt == d) ? dev_sel : '0;
        end
        if (!got_ready) begin
            check("completion", 32'(got_ready), 32'd1);
            sb.delete();
        end
        pr_req = 1'b0;
        dev_ack = '0;
        check("int_req", 32'(int_req), 32'(|(m_pend & m_mask)));
    endtask

    // Change the irq lines while idle; int_req follows pend by one edge.
    task automatic irq_step(input logic [N_DEV-1:0] irq_new);
        logic old_req;
        old_req = |(m_pend & m_mask);
        dev_irq = irq_new;
        m_pend = m_pend | (irq_new & ~m_irq);
        m_irq = irq_new;
        @(posedge clk); #1;
        check("int_req_lag", 32'(int_req), 32'(old_req));
        @(posedge clk); #1;
        check("int_req", 32'(int_req), 32'(|(m_pend & m_mask)));
    endtask

    initial begin
        int r, ready_before;
        logic [31:0] a;
        reset = 1'b1;
        pr_req = 1'b0; pr_we = 1'b0; pr_addr = '0; pr_wd = '0;
        dev_rd = '0; dev_ack = '0; dev_irq = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(pr_ready), 32'd0);
        check("rst_sel", 32'(dev_sel), 32'd0);
        check("rst_int_req", 32'(int_req), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Device 1 read, ack on third ACCESS cycle.
        do_access(1'b0, 32'h7F14, 32'h0, 3, m_irq);
        // Unmapped write.
        do_access(1'b1, 32'h0000_1000, 32'h1234_5678, 1, m_irq);
        // Missing ack: timeout error, or a long wait without the timeout feature.
        if (TO_EN) do_access(1'b0, 32'h7F00, 32'h0, 0, m_irq);
        else       do_access(1'b0, 32'h7F00, 32'h0, 100, m_irq);

        // Interrupt path.
        do_access(1'b1, 32'h7F20, 32'h2, 1, m_irq);
        irq_step(2'b10);
        do_access(1'b0, 32'h7F24, 32'h0, 1, m_irq);
        do_access(1'b1, 32'h7F24, 32'h2, 1, m_irq);
        irq_step(2'b00);
        irq_step(2'b01);
        do_access(1'b0, 32'h7F24, 32'h0, 1, m_irq);
        // Same-edge clear and new rising edge on bit 1: set wins.
        do_access(1'b1, 32'h7F24, 32'h2, 1, 2'b11);
        do_access(1'b0, 32'h7F24, 32'h0, 1, m_irq);
        do_access(1'b0, 32'h7F20, 32'h0, 1, m_irq);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 4)      a = BASE + 32'($urandom_range(0, N_DEV - 1) * WIN) + 32'($urandom_range(0, WIN - 1));
            else if (r <= 6) a = BASE + 32'(N_DEV * WIN) + 32'($urandom_range(0, 2) * 4);
            else if (r == 7) a = 32'($urandom_range(0, 32'h7EFF));
            else             a = BASE + 32'(N_DEV * WIN) + 32'(WIN) + 32'($urandom_range(0, 32'h1000));
            if (r == 9) irq_step(N_DEV'($urandom()));
            else do_access(1'($urandom()), a, $urandom(), $urandom_range(1, 4),
                           ($urandom_range(0, 3) == 0) ? N_DEV'($urandom()) : m_irq);
        end

        // Asynchronous reset in the middle of a device access.
        do_access(1'b1, 32'h7F20, 32'h3, 1, m_irq);
        irq_step(2'b00);
        irq_step(2'b11);
        pr_req = 1'b1; pr_we = 1'b1; pr_addr = 32'h7F08; pr_wd = 32'hA5A5_5A5A;
        repeat (3) begin @(posedge clk); #1; end
        check("pre_rst_sel", 32'(dev_sel), 32'h1);
        dev_irq = '0;
        #2 reset = 1'b1;
        #1;
        check("arst_ready", 32'(pr_ready), 32'd0);
        check("arst_err", 32'(pr_err), 32'd0);
        check("arst_sel", 32'(dev_sel), 32'd0);
        check("arst_we", 32'(dev_we), 32'd0);
        check("arst_int_req", 32'(int_req), 32'd0);
        check("arst_rd", pr_rd, 32'd0);
        check("arst_addr", 32'(dev_addr), 32'd0);
        check("arst_wd", dev_wd, 32'd0);
        pr_req = 1'b0;
        sb.delete();
        m_mask = '0; m_pend = '0; m_irq = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        ready_before = n_ready;
        dev_ack = 2'b01;
        repeat (4) begin @(posedge clk); #1; end
        dev_ack = '0;
        check("late_ack_ready", 32'(n_ready - ready_before), 32'd0);
        do_access(1'b0, 32'h7F24, 32'h0, 1, m_irq);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
